// File: rtl/vproc_resp_pkg.sv
// Shared types and constants for the VProc bus responder.
package vproc_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vproc_resp_lfsr.sv
// 16-bit Galois LFSR that supplies random wait-state counts, one step per accepted beat.
module vproc_resp_lfsr (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Seed,
  input  logic        Advance,
  output logic [15:0] Value
);
  import vproc_resp_pkg::*;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Value <= Seed;
    end else if (Advance) begin
      Value <= {1'b0, Value[15:1]} ^ (Value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/vproc_bus_responder.sv
// Target-side VProc bus model: word-addressed memory window with programmable wait states.
// Define VPROC_RESP_RANDWAIT_EN to randomise each beat's wait within 0..W using an LFSR.
module vproc_bus_responder #(
  parameter int unsigned MEM_ADDR_WIDTH    = 10,
  parameter logic [31:0] BASE_ADDR         = 32'h0,
  parameter int unsigned WAIT_STATES       = 1,
  parameter int unsigned BURST_WAIT_STATES = 0,
  parameter logic [31:0] ERR_DATA          = vproc_resp_pkg::ERR_DATA_DEFAULT,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        WRAck,
  output logic        RDAck,
  input  logic [11:0] Burst,
  input  logic        BurstFirst,
  input  logic        BurstLast,
  output logic        AccessErr
);
  import vproc_resp_pkg::*;

  localparam int unsigned DEPTH = 2 ** MEM_ADDR_WIDTH;

  logic [31:0]               mem [DEPTH];
  resp_state_t               state_q, state_d;
  logic [31:0]               cnt_q, cnt_d;
  logic                      we_q, rd_q;
  logic [31:0]               offset;
  logic                      hit;
  logic [MEM_ADDR_WIDTH-1:0] index;
  logic                      burst_cont;
  logic [31:0]               wait_eff;
  logic                      accept, do_access;
  logic                      op_we, op_rd;
  logic                      wr_ack_d, rd_ack_d, err_d;

  // Addresses below BASE_ADDR wrap to huge offsets and so decode as misses.
  assign offset     = Addr - BASE_ADDR;
  assign hit        = (offset >> MEM_ADDR_WIDTH) == 32'd0;
  assign index      = offset[MEM_ADDR_WIDTH-1:0];
  assign burst_cont = (Burst != 12'd0) && !BurstFirst;

`ifdef VPROC_RESP_RANDWAIT_EN
  logic [15:0] lfsr;
  logic [31:0] rand_single, rand_burst;
  logic        unused_ok;

  vproc_resp_lfsr u_lfsr (
    .Clk     (Clk),
    .Reset   (Reset),
    .Seed    (LFSR_SEED),
    .Advance (accept),
    .Value   (lfsr)
  );

  // Both divisors are constants, so each modulo folds to fixed logic.
  assign rand_single = {16'd0, lfsr} % (WAIT_STATES + 32'd1);
  assign rand_burst  = {16'd0, lfsr} % (BURST_WAIT_STATES + 32'd1);
  assign wait_eff    = burst_cont ? rand_burst : rand_single;
  assign unused_ok   = BurstLast;
`else
  logic unused_ok;

  assign wait_eff  = burst_cont ? BURST_WAIT_STATES : WAIT_STATES;
  assign unused_ok = ^{BurstLast, LFSR_SEED};
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (WE || RD) begin
          accept = 1'b1;
          if (wait_eff == 32'd0) begin
            do_access = 1'b1;
            state_d   = ACK;
          end else begin
            cnt_d   = wait_eff;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 32'd1) begin
          cnt_d     = '0;
          do_access = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      // The request seen on the ACK edge is the one just served, so it is ignored.
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access kind is latched at acceptance so a dropped request still gets its ack.
  always_comb begin
    op_we    = (state_q == IDLE) ? WE : we_q;
    op_rd    = (state_q == IDLE) ? RD : rd_q;
    wr_ack_d = do_access && op_we;
    rd_ack_d = do_access && op_rd;
    err_d    = do_access && (!hit || (op_we && op_rd));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WRAck     <= 1'b0;
      RDAck     <= 1'b0;
      AccessErr <= 1'b0;
      DataOut   <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      WRAck     <= wr_ack_d;
      RDAck     <= rd_ack_d;
      AccessErr <= err_d;
      if (accept) begin
        we_q <= WE;
        rd_q <= RD;
      end
      if (rd_ack_d) begin
        DataOut <= hit ? mem[index] : ERR_DATA;
      end
    end
  end

  // Memory contents survive reset; a simultaneous read sees the pre-write word.
  always_ff @(posedge Clk) begin
    if (wr_ack_d && hit && !Reset) begin
      mem[index] <= DataIn;
    end
  end

endmodule

// File: tb/tb_vproc_bus_responder.sv
// Randomised self-checking bench for vproc_bus_responder against a word-map reference model.
module tb_vproc_bus_responder;

  localparam int unsigned AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef VPROC_RESP_RANDWAIT_EN
  localparam int unsigned WS   = 7;
`else
  localparam int unsigned WS   = 2;
`endif
  localparam int unsigned BWS  = 0;
  localparam logic [31:0] ERR  = 32'hDEADBEEF;
  localparam int          TMO  = 40;

  logic        Clk, Reset;
  logic [31:0] Addr, DataIn, DataOut;
  logic        WE, RD, WRAck, RDAck, AccessErr;
  logic [11:0] Burst;
  logic        BurstFirst, BurstLast;

  vproc_bus_responder #(
    .MEM_ADDR_WIDTH    (AW),
    .BASE_ADDR         (BASE),
    .WAIT_STATES       (WS),
    .BURST_WAIT_STATES (BWS),
    .ERR_DATA          (ERR),
    .LFSR_SEED         (16'hACE1)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Addr       (Addr),
    .WE         (WE),
    .RD         (RD),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .WRAck      (WRAck),
    .RDAck      (RDAck),
    .Burst      (Burst),
    .BurstFirst (BurstFirst),
    .BurstLast  (BurstLast),
    .AccessErr  (AccessErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model [int unsigned];
  bit          lat_seen [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < (32'd1 << AW);
  endfunction

  task automatic check_lat(input string tag, input int lat, input int unsigned w);
`ifdef VPROC_RESP_RANDWAIT_EN
    check(tag, 32'(lat >= 1 && lat <= int'(w) + 1), 32'd1);
`else
    check(tag, 32'(lat), 32'(w + 1));
`endif
  endtask

  // One beat: present request, wait for the ack, check it against the model, then let it drop.
  task automatic op(input logic [31:0] a, input bit w, input bit r, input logic [31:0] d,
                    input logic [11:0] b, input bit bf, input bit bl, input string tag);
    int          lat;
    int unsigned wsel;
    bit          hit, known;
    logic [31:0] off, exp_rd;
    off    = a - BASE;
    hit    = in_win(a);
    wsel   = (b != 12'd0 && !bf) ? BWS : WS;
    known  = hit ? bit'(model.exists(off)) : 1'b1;
    exp_rd = !hit ? ERR : (known ? model[off] : 32'h0);
    Addr = a; WE = w; RD = r; DataIn = d; Burst = b; BurstFirst = bf; BurstLast = bl;
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!(WRAck || RDAck) && lat < TMO);
    check({tag, "_acks"}, {30'd0, WRAck, RDAck}, {30'd0, w, r});
    check({tag, "_err"}, {31'd0, AccessErr}, {31'd0, (!hit || (w && r))});
    check_lat({tag, "_lat"}, lat, wsel);
    lat_seen[lat] = 1'b1;
    if (r && known) check({tag, "_data"}, DataOut, exp_rd);
    if (w && hit) model[off] = d;
    @(posedge Clk); #1;
    check({tag, "_drop"}, {29'd0, WRAck, RDAck, AccessErr}, 32'd0);
  endtask

  task automatic idle();
    WE = 1'b0; RD = 1'b0; Burst = '0; BurstFirst = 1'b0; BurstLast = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    int lat;
    Reset = 1'b1; Addr = '0; WE = 1'b0; RD = 1'b0; DataIn = '0;
    Burst = '0; BurstFirst = 1'b0; BurstLast = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_wrack", {31'd0, WRAck}, 32'd0);
    check("rst_rdack", {31'd0, RDAck}, 32'd0);
    check("rst_err", {31'd0, AccessErr}, 32'd0);
    check("rst_dout", DataOut, 32'd0);
    Reset = 1'b0;

    op(BASE + 5, 1, 0, 32'h12345678, 0, 0, 0, "wr5"); idle();
    op(BASE + 5, 0, 1, 32'h0, 0, 0, 0, "rd5"); idle();

    for (int i = 0; i < 4; i++)
      op(BASE + 32'h10 + i, 1, 0, 32'hB000_0000 + i, 12'(4 - i), i == 0, i == 3, "bwr");
    idle();
    for (int i = 0; i < 4; i++)
      op(BASE + 32'h10 + i, 0, 1, 32'h0, 12'(4 - i), i == 0, i == 3, "brd");
    idle();

    op(BASE, 1, 0, 32'hC0FFEE00, 0, 0, 0, "wr0"); idle();
    op(BASE + 1024, 0, 1, 32'h0, 0, 0, 0, "miss_rd"); idle();
    op(BASE + 1024, 1, 0, 32'h55555555, 0, 0, 0, "miss_wr"); idle();
    op(BASE, 0, 1, 32'h0, 0, 0, 0, "rd0"); idle();
    op(BASE - 1, 0, 1, 32'h0, 0, 0, 0, "wrap_rd"); idle();

    op(BASE + 7, 1, 0, 32'hA5A5A5A5, 0, 0, 0, "wr7"); idle();
    op(BASE + 7, 1, 1, 32'h00000001, 0, 0, 0, "both7"); idle();
    op(BASE + 7, 0, 1, 32'h0, 0, 0, 0, "rd7"); idle();

    // Reset while the read is waiting, then the held request is served again.
    Addr = BASE + 5; RD = 1'b1; WE = 1'b0;
    @(posedge Clk); #3;
    Reset = 1'b1; #1;
    check("rstw_acks", {30'd0, WRAck, RDAck}, 32'd0);
    check("rstw_dout", DataOut, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!RDAck && lat < TMO);
    check("rstw_rdack", {31'd0, RDAck}, 32'd1);
    check_lat("rstw_lat", lat, WS);
    check("rstw_data", DataOut, model[32'd5]);
    @(posedge Clk); #1;
    check("rstw_drop", {31'd0, RDAck}, 32'd0);
    idle();

    // Reset while the ack is high must kill it at once.
    Addr = BASE + 5; RD = 1'b1;
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!RDAck && lat < TMO);
    check("rsta_seen", {31'd0, RDAck}, 32'd1);
    #2 Reset = 1'b1; #1;
    check("rsta_drop", {30'd0, WRAck, RDAck}, 32'd0);
    RD = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle();

    lat_seen.delete();
    for (int t = 0; t < 400; t++) begin
      int          len, k, sel;
      logic [31:0] a0;
      bit          w, r;
      len = int'($urandom_range(1, 4));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a0 = BASE + 32'd1024 + $urandom_range(0, 7);
      else if (sel == 1) a0 = BASE - $urandom_range(1, 8);
      else               a0 = BASE + $urandom_range(0, 63);
      k = int'($urandom_range(0, 9));
      w = (k <= 4);
      r = (k == 0) || (k >= 5);
      for (int i = 0; i < len; i++)
        op(a0 + i, w, r, $urandom, (len == 1) ? 12'd0 : 12'(len - i),
           len > 1 && i == 0, len > 1 && i == len - 1, "rnd");
      if ($urandom_range(0, 1) == 1) idle();
      else begin
        WE = 1'b0; RD = 1'b0;
      end
    end
    idle();
`ifdef VPROC_RESP_RANDWAIT_EN
    check("distinct_lat", 32'(lat_seen.num() >= 4), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
